sid_array_sched: RTL and testbench

SID_ARRAY_SCHED -- requirements
Module: sid_array_sched

---
 rtl/sid_array_sched.sv | 147 ++++++++++++++
 tb/tb_sid_array_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sid_array_sched.sv
// Time-multiplexes one combined-waveform table and one filter across several SID chips.
// A ce_1m strobe starts a fixed sequence: per-voice table lookups, then one filter window per chip.
module sid_array_sched #(
    parameter int CHIPS       = 2,
    parameter int ACC_W       = 12,
    parameter int OUT_W       = 8,
    parameter int AUD_W       = 18,
    parameter int TBL_LAT     = 2,
    parameter int FILT_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce_1m,
    input  logic [CHIPS*3*ACC_W-1:0]     acc_t_in,
    output logic [ACC_W-1:0]             tbl_acc,
    output logic [1:0]                   tbl_sel,
    input  logic [4*OUT_W-1:0]           tbl_data,
    output logic [CHIPS*3*4*OUT_W-1:0]   wave_out,
    output logic [1:0]                   filt_chip,
    output logic [2:0]                   filt_state,
    input  logic [AUD_W-1:0]             filt_audio,
    output logic [CHIPS*AUD_W-1:0]       audio_out,
    output logic                         audio_valid,
    output logic                         busy,
    output logic                         overrun
);
    localparam int NV = 3 * CHIPS;
    localparam int WV = 4 * OUT_W;
    localparam int B  = NV + TBL_LAT;
    localparam int T  = B + CHIPS * FILT_CYCLES;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 p_q, p_d;
    logic [NV*ACC_W-1:0]        snap_q, snap_d;
    logic [ACC_W-1:0]           tbl_acc_q, tbl_acc_d;
    logic [1:0]                 tbl_sel_q, tbl_sel_d;
    logic [NV*WV-1:0]           wave_q, wave_d;
    logic [1:0]                 filt_chip_q, filt_chip_d;
    logic [2:0]                 filt_state_q, filt_state_d;
    logic [CHIPS*AUD_W-1:0]     hold_q, hold_d;
    logic [CHIPS*AUD_W-1:0]     audio_q, audio_d;
    logic                       audio_valid_q, audio_valid_d;
    logic                       overrun_q, overrun_d;

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        snap_d        = snap_q;
        tbl_acc_d     = tbl_acc_q;
        tbl_sel_d     = tbl_sel_q;
        wave_d        = wave_q;
        hold_d        = hold_q;
        audio_d       = audio_q;
        audio_valid_d = 1'b0;
        overrun_d     = overrun_q;
        filt_chip_d   = 2'd0;
        filt_state_d  = 3'd7;

        if (state_q == ST_RUN) begin
            for (int k = 0; k < NV; k++) begin
                if (p_q == 8'(k + TBL_LAT)) wave_d[k*WV +: WV] = tbl_data;
            end
            for (int c = 0; c < CHIPS; c++) begin
                if (p_q == 8'(B + (c + 1) * FILT_CYCLES - 1)) hold_d[c*AUD_W +: AUD_W] = filt_audio;
            end
            // Last chip's sample lands in hold_d on the same edge that publishes audio_out.
            if (p_q == 8'(T - 1)) begin
                state_d       = ST_IDLE;
                audio_d       = hold_d;
                audio_valid_d = 1'b1;
            end else begin
                p_d = p_q + 8'd1;
            end
        end

        if (ce_1m) begin
            if (state_q == ST_RUN) begin
                overrun_d     = 1'b1;
                hold_d        = '0;
                audio_d       = audio_q;
                audio_valid_d = 1'b0;
            end
            state_d = ST_RUN;
            p_d     = 8'd0;
            snap_d  = acc_t_in;
        end

        // Outputs are registered, so they are decoded from the phase of the coming cycle.
        if (state_d == ST_RUN) begin
            for (int k = 0; k < NV; k++) begin
                if (p_d == 8'(k)) begin
                    tbl_acc_d = snap_d[k*ACC_W +: ACC_W];
                    tbl_sel_d = 2'(k / 3);
                end
            end
            for (int c = 0; c < CHIPS; c++) begin
                if (p_d >= 8'(B + c * FILT_CYCLES) && p_d < 8'(B + (c + 1) * FILT_CYCLES)) begin
                    filt_chip_d  = 2'(c);
                    filt_state_d = 3'(p_d - 8'(B + c * FILT_CYCLES));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            p_q           <= 8'd0;
            snap_q        <= '0;
            tbl_acc_q     <= '0;
            tbl_sel_q     <= 2'd0;
            wave_q        <= '0;
            filt_chip_q   <= 2'd0;
            filt_state_q  <= 3'd7;
            hold_q        <= '0;
            audio_q       <= '0;
            audio_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            snap_q        <= snap_d;
            tbl_acc_q     <= tbl_acc_d;
            tbl_sel_q     <= tbl_sel_d;
            wave_q        <= wave_d;
            filt_chip_q   <= filt_chip_d;
            filt_state_q  <= filt_state_d;
            hold_q        <= hold_d;
            audio_q       <= audio_d;
            audio_valid_q <= audio_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign tbl_acc     = tbl_acc_q;
    assign tbl_sel     = tbl_sel_q;
    assign wave_out    = wave_q;
    assign filt_chip   = filt_chip_q;
    assign filt_state  = filt_state_q;
    assign audio_out   = audio_q;
    assign audio_valid = audio_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sid_array_sched.sv
// Scoreboard bench for sid_array_sched: a phase-level reference model predicts every cycle,
// completed audio frames are queued and popped whenever the DUT pulses audio_valid.
module tb_sid_array_sched;
    localparam int CHIPS = 2, ACC_W = 12, OUT_W = 8, AUD_W = 18, TBL_LAT = 2, FC = 8;
    localparam int NV = 3 * CHIPS;
    localparam int B  = NV + TBL_LAT;
    localparam int T  = B + CHIPS * FC;

    logic clk = 0, reset = 1, ce_1m = 0;
    logic [NV*ACC_W-1:0]        acc_t_in = '0;
    logic [ACC_W-1:0]           tbl_acc;
    logic [1:0]                 tbl_sel, filt_chip;
    logic [4*OUT_W-1:0]         tbl_data;
    logic [NV*4*OUT_W-1:0]      wave_out;
    logic [2:0]                 filt_state;
    logic [AUD_W-1:0]           filt_audio = '0;
    logic [CHIPS*AUD_W-1:0]     audio_out;
    logic                       audio_valid, busy, overrun;

    sid_array_sched #(.CHIPS(CHIPS), .ACC_W(ACC_W), .OUT_W(OUT_W), .AUD_W(AUD_W),
                      .TBL_LAT(TBL_LAT), .FILT_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .ce_1m(ce_1m), .acc_t_in(acc_t_in),
        .tbl_acc(tbl_acc), .tbl_sel(tbl_sel), .tbl_data(tbl_data), .wave_out(wave_out),
        .filt_chip(filt_chip), .filt_state(filt_state), .filt_audio(filt_audio),
        .audio_out(audio_out), .audio_valid(audio_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Table block stand-in: {4{acc[7:0]}} two cycles after the address.
    logic [ACC_W-1:0] tq1 = '0, tq2 = '0;
    always @(posedge clk) begin tq1 <= tbl_acc; tq2 <= tq1; end
    assign tbl_data = {4{tq2[7:0]}};

    int n_pass = 0, n_total = 0;
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: tracks the sequence phase and what each output must show in the next cycle.
    bit                     m_busy = 0, m_overrun = 0, m_exp_valid = 0;
    int                     m_p = 0;
    logic [ACC_W-1:0]       m_snap [NV];
    logic [4*OUT_W-1:0]     m_wave [NV];
    logic [AUD_W-1:0]       m_hold [CHIPS];
    logic [CHIPS*AUD_W-1:0] m_audio = '0;
    logic [ACC_W-1:0]       m_tbl_acc = '0;
    logic [1:0]             m_tbl_sel = '0;
    logic [CHIPS*AUD_W-1:0] exp_q [$];

    always @(posedge clk) begin
        bit was_run;
        if (reset) begin
            m_busy = 0; m_overrun = 0; m_exp_valid = 0; m_audio = '0;
            m_tbl_acc = '0; m_tbl_sel = '0;
            for (int k = 0; k < NV; k++) m_wave[k] = '0;
            for (int c = 0; c < CHIPS; c++) m_hold[c] = '0;
        end else begin
            was_run = m_busy;
            m_exp_valid = 0;
            if (m_busy) begin
                if (m_p >= TBL_LAT && m_p - TBL_LAT < NV) m_wave[m_p - TBL_LAT] = tbl_data;
                if (m_p >= B && ((m_p - B + 1) % FC) == 0) m_hold[(m_p - B) / FC] = filt_audio;
                if (m_p == T - 1) m_busy = 0; else m_p++;
            end
            if (ce_1m) begin
                if (was_run) begin
                    m_overrun = 1;
                    for (int c = 0; c < CHIPS; c++) m_hold[c] = '0;
                end
                m_busy = 1; m_p = 0;
                for (int k = 0; k < NV; k++) m_snap[k] = acc_t_in[k*ACC_W +: ACC_W];
            end else if (was_run && !m_busy) begin
                for (int c = 0; c < CHIPS; c++) m_audio[c*AUD_W +: AUD_W] = m_hold[c];
                exp_q.push_back(m_audio);
                m_exp_valid = 1;
            end
            if (m_busy && m_p < NV) begin
                m_tbl_acc = m_snap[m_p];
                m_tbl_sel = 2'(m_p / 3);
            end
        end
    end

    // Monitor
    initial begin
        logic [1:0]           fchip;
        logic [2:0]           fstate;
        logic [NV*4*OUT_W-1:0] ewave;
        forever begin
            @(posedge clk); #1;
            fchip = 0; fstate = 7;
            if (m_busy && m_p >= B) begin
                fchip  = 2'((m_p - B) / FC);
                fstate = 3'((m_p - B) % FC);
            end
            for (int k = 0; k < NV; k++) ewave[k*4*OUT_W +: 4*OUT_W] = m_wave[k];
            check("ctl", {busy, tbl_acc, tbl_sel, filt_chip, filt_state, overrun},
                         {m_busy, m_tbl_acc, m_tbl_sel, fchip, fstate, m_overrun});
            check("wave", wave_out, ewave);
            check("audio_valid", audio_valid, m_exp_valid);
            check("audio_hold", audio_out, m_audio);
            if (audio_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL audio_out: got pulse with %h expected no pulse", audio_out);
                end else begin
                    check("audio_out", audio_out, exp_q.pop_front());
                end
            end
        end
    end

    bit dir_mode = 1;
    initial forever begin
        @(negedge clk);
        filt_audio = dir_mode ? AUD_W'(32'h1000 + m_p) : AUD_W'($urandom);
    end

    task automatic pulse_ce(input logic [NV*ACC_W-1:0] acc);
        acc_t_in = acc; ce_1m = 1;
        @(negedge clk); ce_1m = 0;
    endtask

    initial begin
        logic [NV*ACC_W-1:0]    acc;
        logic [CHIPS*AUD_W-1:0] prev_audio;
        logic [31:0]            v4;
        repeat (3) @(negedge clk);
        reset = 0;
        check("rst_filt_state", filt_state, 3'd7);
        check("rst_busy", busy, 1'b0);

        // Directed sequence with voice k = 0x100+k and filt_audio = 0x1000+p
        for (int k = 0; k < NV; k++) acc[k*ACC_W +: ACC_W] = ACC_W'(12'h100 + k);
        pulse_ce(acc);
        for (int p = 0; p < NV; p++) begin
            check("lookup_acc", tbl_acc, 12'h100 + p);
            check("lookup_sel", tbl_sel, 2'(p / 3));
            @(negedge clk);
        end
        repeat (T - NV) @(negedge clk);
        v4 = wave_out[4*32 +: 32];
        check("p24_valid", audio_valid, 1'b1);
        check("p24_busy", busy, 1'b0);
        check("audio_const", audio_out, {18'h1017, 18'h100F});
        check("wave_v4", v4, 32'h04040404);

        // ce_1m coincident with audio_valid
        acc = {$urandom, $urandom, $urandom};
        pulse_ce(acc);
        check("coinc_acc", tbl_acc, acc[ACC_W-1:0]);
        check("coinc_overrun", overrun, 1'b0);
        repeat (T + 6) @(negedge clk);

        // Overrun at p=10
        pulse_ce({$urandom, $urandom, $urandom});
        repeat (10) @(negedge clk);
        prev_audio = audio_out;
        pulse_ce({$urandom, $urandom, $urandom});
        check("overrun_set", overrun, 1'b1);
        repeat (T - 1) @(negedge clk);
        check("overrun_hold_audio", audio_out, prev_audio);
        check("overrun_no_valid", audio_valid, 1'b0);
        @(negedge clk);
        check("overrun_late_valid", audio_valid, 1'b1);
        repeat (10) @(negedge clk);

        // Reset at p=15
        pulse_ce({$urandom, $urandom, $urandom});
        repeat (15) @(negedge clk);
        reset = 1;
        @(negedge clk); reset = 0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_audio", audio_out, '0);
        check("midrst_wave", wave_out, '0);
        check("midrst_overrun", overrun, 1'b0);
        repeat (T + 6) @(negedge clk);

        // Random traffic
        dir_mode = 0;
        for (int i = 0; i < 600; i++) begin
            ce_1m = ($urandom_range(0, 27) == 0);
            if (ce_1m) acc_t_in = {$urandom, $urandom, $urandom};
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        ce_1m = 0; reset = 0;
        repeat (T + 8) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
